// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I decode-stage immediate generator with a 2-entry skid buffer; IMMGEN_ILLEGAL_EN flags bad opcodes.
// Latency 1 cycle from acceptance to out_valid; one instruction per cycle while out_ready is high.
// Back-pressure: in_ready is the registered complement of skid occupancy, so it never depends on out_ready.
module imm_gen_pipe #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;
   localparam logic [2:0] FMT_Z = 3'd6;
`ifdef IMMGEN_ILLEGAL_EN
   localparam logic [2:0] FMT_BAD = 3'd7;
`else
   localparam logic [2:0] FMT_BAD = FMT_R;
`endif

   logic [6:0]      w_op;
   logic [2:0]      w_fmt;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic            w_acc;
   logic            w_xfer;

   logic            r_main_vld;
   logic [31:0]     r_main_instr;
   logic [XLEN-1:0] r_main_pc;
   logic [XLEN-1:0] r_main_imm;
   logic [2:0]      r_main_fmt;

   logic            r_skid_vld;
   logic [31:0]     r_skid_instr;
   logic [XLEN-1:0] r_skid_pc;
   logic [XLEN-1:0] r_skid_imm;
   logic [2:0]      r_skid_fmt;

   assign w_op = in_instr[6:0];

   // Every legal opcode ends in 2'b11, so a full 7-bit match also rejects compressed encodings.
   always_comb begin
      w_fmt   = FMT_BAD;
      w_imm32 = 32'd0;
      case (w_op)
         7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111: begin
            w_fmt   = FMT_I;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         7'b0011011: begin
            if (XLEN == 64) begin
               w_fmt   = FMT_I;
               w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
         end
         7'b0100011: begin
            w_fmt   = FMT_S;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         7'b1100011: begin
            w_fmt   = FMT_B;
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            w_fmt   = FMT_U;
            w_imm32 = {in_instr[31:12], 12'd0};
         end
         7'b1101111: begin
            w_fmt   = FMT_J;
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
         end
         7'b1110011: begin
            if (in_instr[14]) begin
               w_fmt   = FMT_Z;
               w_imm32 = {27'd0, in_instr[19:15]};
            end else begin
               w_fmt   = FMT_R;
            end
         end
         7'b0110011: w_fmt = FMT_R;
         7'b0111011: begin
            if (XLEN == 64) w_fmt = FMT_R;
         end
         default: ;
      endcase
   end

   // Z immediates are at most 5 bits, so sign extension of w_imm32 is also correct for them.
   assign w_imm = XLEN'($signed(w_imm32));

   assign in_ready = !r_skid_vld;
   assign w_acc    = in_valid && in_ready;
   assign w_xfer   = r_main_vld && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_vld   <= 1'b0;
         r_main_instr <= '0;
         r_main_pc    <= '0;
         r_main_imm   <= '0;
         r_main_fmt   <= '0;
         r_skid_vld   <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
         r_skid_imm   <= '0;
         r_skid_fmt   <= '0;
      end else if (flush) begin
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else if (!r_main_vld || w_xfer) begin
         if (r_skid_vld) begin
            r_main_vld   <= 1'b1;
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_main_imm   <= r_skid_imm;
            r_main_fmt   <= r_skid_fmt;
            r_skid_vld   <= 1'b0;
         end else begin
            r_main_vld <= w_acc;
            if (w_acc) begin
               r_main_instr <= in_instr;
               r_main_pc    <= in_pc;
               r_main_imm   <= w_imm;
               r_main_fmt   <= w_fmt;
            end
         end
      end else if (w_acc) begin
         r_skid_vld   <= 1'b1;
         r_skid_instr <= in_instr;
         r_skid_pc    <= in_pc;
         r_skid_imm   <= w_imm;
         r_skid_fmt   <= w_fmt;
      end
   end

   assign out_valid = r_main_vld;
   assign out_instr = r_main_instr;
   assign out_pc    = r_main_pc;
   assign out_imm   = r_main_imm;
   assign out_fmt   = r_main_fmt;
`ifdef IMMGEN_ILLEGAL_EN
   assign out_illegal = (r_main_fmt == 3'd7);
`else
   assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: format-decode vector table on XLEN=64 and XLEN=32 instances, then skid, flush and reset sequences.
module tb_imm_gen_pipe;

`ifdef IMMGEN_ILLEGAL_EN
   localparam logic [2:0] ILLF = 3'd7;
`else
   localparam logic [2:0] ILLF = 3'd0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        rdy64, vld64, ill64;
   logic [31:0] instr64;
   logic [63:0] pc64, imm64;
   logic [2:0]  fmt64;

   logic        rdy32, vld32, ill32;
   logic [31:0] instr32;
   logic [31:0] pc32, imm32;
   logic [2:0]  fmt32;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(64)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(vld64), .out_ready(out_ready), .out_instr(instr64), .out_pc(pc64),
      .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
   );

   imm_gen_pipe #(.XLEN(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(vld32), .out_ready(out_ready), .out_instr(instr32), .out_pc(pc32),
      .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
   );

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  f64;
      logic [63:0] i64;
      logic [2:0]  f32;
      logic [31:0] i32;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " out_valid"}, {63'd0, vld64}, 64'd0);
      chk({tag, " in_ready"}, {63'd0, rdy64}, 64'd1);
      chk({tag, " out_instr"}, {32'd0, instr64}, 64'd0);
      chk({tag, " out_pc"}, pc64, 64'd0);
      chk({tag, " out_imm"}, imm64, 64'd0);
      chk({tag, " out_fmt"}, {61'd0, fmt64}, 64'd0);
      chk({tag, " out_illegal"}, {63'd0, ill64}, 64'd0);
   endtask

   initial begin
      vecs[0]  = '{32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFFFFFFFF};
      vecs[1]  = '{32'hFE20AE23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 32'hFFFFFFFC};
      vecs[2]  = '{32'h80000063, 3'd3, 64'hFFFFFFFFFFFFF000, 3'd3, 32'hFFFFF000};
      vecs[3]  = '{32'h0010006F, 3'd5, 64'h0000000000000800, 3'd5, 32'h00000800};
      vecs[4]  = '{32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 32'h80000000};
      vecs[5]  = '{32'h3057D073, 3'd6, 64'h000000000000000F, 3'd6, 32'h0000000F};
      vecs[6]  = '{32'h00008033, 3'd0, 64'h0,                3'd0, 32'h0};
      vecs[7]  = '{32'h00000000, ILLF, 64'h0,                ILLF, 32'h0};
      vecs[8]  = '{32'h0000003B, 3'd0, 64'h0,                ILLF, 32'h0};
      vecs[9]  = '{32'hFFF0009B, 3'd1, 64'hFFFFFFFFFFFFFFFF, ILLF, 32'h0};
      vecs[10] = '{32'h00000073, 3'd0, 64'h0,                3'd0, 32'h0};
      vecs[11] = '{32'h12345097, 3'd4, 64'h0000000012345000, 3'd4, 32'h12345000};
      vecs[12] = '{32'h7FF02083, 3'd1, 64'h00000000000007FF, 3'd1, 32'h000007FF};
      vecs[13] = '{32'h00000010, ILLF, 64'h0,                ILLF, 32'h0};
      vecs[14] = '{32'h800000E7, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1, 32'hFFFFF800};
      vecs[15] = '{32'h00000FE3, 3'd3, 64'h000000000000081E, 3'd3, 32'h0000081E};
      vecs[16] = '{32'h8000006F, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5, 32'hFFF00000};
      vecs[17] = '{32'h0000000F, 3'd1, 64'h0,                3'd1, 32'h0};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0;
      #1;
      chk_reset_outs("reset");
      step();
      rst_n = 1'b1;

      // Back-to-back table stream: each result is visible one edge after its acceptance.
      for (int k = 0; k < 18; k++) begin
         in_valid = 1'b1;
         in_instr = vecs[k].instr;
         in_pc    = 64'h8000_1000_0000_0000 + 64'(k * 4);
         step();
         chk($sformatf("v%0d valid64", k), {63'd0, vld64}, 64'd1);
         chk($sformatf("v%0d fmt64", k), {61'd0, fmt64}, {61'd0, vecs[k].f64});
         chk($sformatf("v%0d imm64", k), imm64, vecs[k].i64);
         chk($sformatf("v%0d ill64", k), {63'd0, ill64}, {63'd0, vecs[k].f64 == 3'd7});
         chk($sformatf("v%0d pc64", k), pc64, 64'h8000_1000_0000_0000 + 64'(k * 4));
         chk($sformatf("v%0d instr64", k), {32'd0, instr64}, {32'd0, vecs[k].instr});
         chk($sformatf("v%0d fmt32", k), {61'd0, fmt32}, {61'd0, vecs[k].f32});
         chk($sformatf("v%0d imm32", k), {32'd0, imm32}, {32'd0, vecs[k].i32});
         chk($sformatf("v%0d ill32", k), {63'd0, ill32}, {63'd0, vecs[k].f32 == 3'd7});
         chk($sformatf("v%0d pc32", k), {32'd0, pc32}, 64'(k * 4));
      end
      in_valid = 1'b0;
      step();
      chk("drain valid", {63'd0, vld64}, 64'd0);

      // Back-pressure: A to main, B to skid, C held off until the first transfer.
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'hA0;
      step();
      chk("bp A in main", pc64, 64'hA0);
      chk("bp rdy after A", {63'd0, rdy64}, 64'd1);
      in_instr = 32'hFE20AE23; in_pc = 64'hB0;
      step();
      chk("bp rdy after B", {63'd0, rdy64}, 64'd0);
      chk("bp A held", pc64, 64'hA0);
      in_instr = 32'h800000B7; in_pc = 64'hC0;
      step();
      chk("bp rdy full", {63'd0, rdy64}, 64'd0);
      chk("bp A stable pc", pc64, 64'hA0);
      chk("bp A stable imm", imm64, 64'hFFFFFFFFFFFFFFFF);
      out_ready = 1'b1;
      step();
      chk("bp B out", pc64, 64'hB0);
      chk("bp B imm", imm64, 64'hFFFFFFFFFFFFFFFC);
      chk("bp rdy back", {63'd0, rdy64}, 64'd1);
      step();
      chk("bp C out", pc64, 64'hC0);
      chk("bp C imm", imm64, 64'hFFFFFFFF80000000);
      chk("bp C valid", {63'd0, vld64}, 64'd1);
      in_valid = 1'b0;
      step();
      chk("bp empty", {63'd0, vld64}, 64'd0);

      // Flush with both entries occupied and an input on offer.
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00008033; in_pc = 64'h100;
      step();
      in_pc = 64'h104;
      step();
      chk("fl full", {63'd0, rdy64}, 64'd0);
      flush = 1'b1; in_pc = 64'h108;
      step();
      chk("fl valid", {63'd0, vld64}, 64'd0);
      chk("fl rdy", {63'd0, rdy64}, 64'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("fl no ghost %0d", k), {63'd0, vld64}, 64'd0);
      end
      // Flush with an otherwise acceptable input: it must be dropped.
      flush = 1'b1; in_valid = 1'b1; in_pc = 64'h200;
      step();
      chk("fl drop", {63'd0, vld64}, 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      step();
      chk("fl drop later", {63'd0, vld64}, 64'd0);

      // Asynchronous reset mid-stream, observed before the next clock edge.
      in_valid = 1'b1; in_instr = 32'h3057D073; in_pc = 64'h300;
      step();
      chk("rst pre valid", {63'd0, vld64}, 64'd1);
      out_ready = 1'b0;
      in_pc = 64'h304;
      step();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outs("async reset");
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      chk("post reset empty", {63'd0, vld64}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not complete, expected finish");
      $fatal(1);
   end

endmodule
